// File: rtl/exp4_hcsr04_interface.sv
// HC-SR04 front end: issues the trigger pulse, times the echo and reports the
// distance as rounded 3-digit BCD centimetres, or flags a timeout.
module exp4_hcsr04_interface #(
    parameter int unsigned TRIGGER_CYCLES = 500,
    parameter int unsigned CYCLES_PER_CM  = 2941,
    parameter int unsigned TIMEOUT_CYCLES = 1500000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        medir,
    input  logic        echo,
    output logic        trigger,
    output logic [11:0] medida,
    output logic        pronto,
    output logic        timeout,
    output logic [3:0]  db_estado
);

    localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > TRIGGER_CYCLES) ? TIMEOUT_CYCLES : TRIGGER_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned TICK_W  = $clog2(CYCLES_PER_CM);

    typedef enum logic [3:0] {
        ST_INICIAL       = 4'd0,
        ST_PREPARA       = 4'd1,
        ST_ENVIA_TRIGGER = 4'd2,
        ST_ESPERA_ECHO   = 4'd3,
        ST_MEDE          = 4'd4,
        ST_ARMAZENA      = 4'd5,
        ST_FINAL         = 4'd6,
        ST_TIMEOUT       = 4'd15
    } estado_t;

    estado_t            estado;
    estado_t            proximo;
    logic               echo_m;
    logic               echo_s;
    logic               echo_d;
    logic               echo_rise;
    logic               echo_fall;
    logic [CNT_W-1:0]   cnt;
    logic [TICK_W-1:0]  tick;
    logic [11:0]        cm_bcd;
    logic [11:0]        cm_round;
    logic               conta;
    logic               cnt_fim_trig;
    logic               cnt_fim_to;
    logic               trigger_n;
    logic               pronto_n;
    logic               timeout_n;
    logic [11:0]        medida_n;

    // Decimal increment that sticks at 999 instead of wrapping.
    function automatic logic [11:0] bcd_inc_sat(input logic [11:0] v);
        logic [3:0] u;
        logic [3:0] t;
        logic [3:0] h;
        u = v[3:0];
        t = v[7:4];
        h = v[11:8];
        if (v == 12'h999) return v;
        if (u != 4'd9) begin
            u = u + 4'd1;
        end else begin
            u = 4'd0;
            if (t != 4'd9) begin
                t = t + 4'd1;
            end else begin
                t = 4'd0;
                h = h + 4'd1;
            end
        end
        return {h, t, u};
    endfunction

    always_ff @(posedge clock) begin
        if (!reset) begin
            echo_m <= 1'b0;
            echo_s <= 1'b0;
            echo_d <= 1'b0;
        end else begin
            echo_m <= echo;
            echo_s <= echo_m;
            echo_d <= echo_s;
        end
    end

    assign echo_rise    = echo_s & ~echo_d;
    assign echo_fall    = ~echo_s & echo_d;
    assign cnt_fim_trig = (cnt == CNT_W'(TRIGGER_CYCLES - 1));
    assign cnt_fim_to   = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    // The rise cycle is itself a high cycle, so it is counted from ESPERA_ECHO.
    assign conta        = ((estado == ST_ESPERA_ECHO) && echo_rise) || ((estado == ST_MEDE) && echo_s);
    assign cm_round     = (tick >= TICK_W'(CYCLES_PER_CM / 2)) ? bcd_inc_sat(cm_bcd) : cm_bcd;
    assign db_estado    = estado;

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado <= ST_INICIAL;
        end else begin
            estado <= proximo;
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        proximo   = estado;
        medida_n  = medida;
        timeout_n = timeout;
        case (estado)
            ST_INICIAL:       if (medir) proximo = ST_PREPARA;
            ST_PREPARA:       proximo = ST_ENVIA_TRIGGER;
            ST_ENVIA_TRIGGER: if (cnt_fim_trig) proximo = ST_ESPERA_ECHO;
            ST_ESPERA_ECHO: begin
                if (echo_rise)       proximo = ST_MEDE;
                else if (cnt_fim_to) proximo = ST_TIMEOUT;
            end
            ST_MEDE: begin
                if (echo_fall)       proximo = ST_ARMAZENA;
                else if (cnt_fim_to) proximo = ST_TIMEOUT;
            end
            ST_ARMAZENA:      proximo = ST_FINAL;
            ST_TIMEOUT:       proximo = ST_FINAL;
            ST_FINAL:         if (medir) proximo = ST_PREPARA;
            default:          proximo = ST_INICIAL;
        endcase
        trigger_n = (proximo == ST_ENVIA_TRIGGER);
        pronto_n  = (proximo == ST_ARMAZENA) || (proximo == ST_TIMEOUT);
        if (proximo == ST_PREPARA) timeout_n = 1'b0;
        if (proximo == ST_TIMEOUT) timeout_n = 1'b1;
        if (proximo == ST_ARMAZENA) medida_n = cm_round;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            trigger <= 1'b0;
            pronto  <= 1'b0;
            timeout <= 1'b0;
            medida  <= 12'h000;
        end else begin
            trigger <= trigger_n;
            pronto  <= pronto_n;
            timeout <= timeout_n;
            medida  <= medida_n;
        end
    end

    // Phase counter restarts on every state change; tick/cm accumulate the echo width.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt    <= '0;
            tick   <= '0;
            cm_bcd <= 12'h000;
        end else if (estado == ST_PREPARA) begin
            cnt    <= '0;
            tick   <= '0;
            cm_bcd <= 12'h000;
        end else begin
            if (proximo != estado) begin
                cnt <= (proximo == ST_MEDE) ? CNT_W'(1) : '0;
            end else if ((estado == ST_ENVIA_TRIGGER) || (estado == ST_ESPERA_ECHO) || (estado == ST_MEDE)) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (conta) begin
                if (tick == TICK_W'(CYCLES_PER_CM - 1)) begin
                    tick   <= '0;
                    cm_bcd <= bcd_inc_sat(cm_bcd);
                end else begin
                    tick <= tick + TICK_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_exp4_hcsr04_interface.sv
// Bench for exp4_hcsr04_interface: randomized echo widths against an arithmetic
// distance model; a second instance with a longer timeout covers saturation.
module tb_exp4_hcsr04_interface;

    localparam int TRIG = 5;
    localparam int CPC  = 10;
    localparam int TO_D = 2000;
    localparam int TO_S = 20000;

    logic        clock = 1'b0;
    logic        reset;
    logic        medir;
    logic        echo;
    logic        trigger_d, pronto_d, timeout_d;
    logic [11:0] medida_d;
    logic [3:0]  estado_d;
    logic        trigger_s, pronto_s, timeout_s;
    logic [11:0] medida_s;
    logic [3:0]  estado_s;

    logic        sel_s = 1'b0;
    logic        obs_trigger, obs_pronto, obs_timeout;
    logic [11:0] obs_medida;
    logic [3:0]  obs_estado;

    int          ntests = 0;
    int          nfail  = 0;
    logic [11:0] exp_medida;
    logic        exp_timeout;

    always #5 clock = ~clock;

    exp4_hcsr04_interface #(.TRIGGER_CYCLES(TRIG), .CYCLES_PER_CM(CPC), .TIMEOUT_CYCLES(TO_D)) dut (
        .clock(clock), .reset(reset), .medir(medir), .echo(echo),
        .trigger(trigger_d), .medida(medida_d), .pronto(pronto_d),
        .timeout(timeout_d), .db_estado(estado_d)
    );

    exp4_hcsr04_interface #(.TRIGGER_CYCLES(TRIG), .CYCLES_PER_CM(CPC), .TIMEOUT_CYCLES(TO_S)) dut_s (
        .clock(clock), .reset(reset), .medir(medir), .echo(echo),
        .trigger(trigger_s), .medida(medida_s), .pronto(pronto_s),
        .timeout(timeout_s), .db_estado(estado_s)
    );

    assign obs_trigger = sel_s ? trigger_s : trigger_d;
    assign obs_pronto  = sel_s ? pronto_s  : pronto_d;
    assign obs_timeout = sel_s ? timeout_s : timeout_d;
    assign obs_medida  = sel_s ? medida_s  : medida_d;
    assign obs_estado  = sel_s ? estado_s  : estado_d;

    // Rounded centimetres from an echo width in clocks.
    function automatic int cm_of(input int n);
        return n / CPC + (((n % CPC) >= CPC / 2) ? 1 : 0);
    endfunction

    function automatic logic [11:0] to_bcd(input int v);
        int q;
        q = (v > 999) ? 999 : v;
        return {4'(q / 100), 4'((q / 10) % 10), 4'(q % 10)};
    endfunction

    // One measurement: optional medir kick, echo of `high` clocks after `gap` (0 = no echo).
    task automatic run_meas(input bit kick, input int gap, input int high, input bit busy);
        int p_cnt, p_at, to, exp_at, total, waited;
        bit exp_to;
        to = sel_s ? TO_S : TO_D;
        if (kick) begin
            @(negedge clock); medir = 1'b1;
            @(negedge clock); medir = 1'b0;
        end
        waited = 0;
        while (obs_estado !== 4'd3 && waited < 100) begin
            @(negedge clock);
            waited++;
        end
        ntests++;
        if (waited >= 100) begin
            nfail++;
            $display("FAIL wait_espera: state %0d, required 3 within 100 cycles", obs_estado);
            return;
        end
        if (high == 0) begin
            exp_to = 1'b1; exp_at = to - 1;
        end else if (high >= to) begin
            exp_to = 1'b1; exp_at = gap + 2 + to;
        end else begin
            exp_to = 1'b0; exp_at = gap + high + 3;
            exp_medida = to_bcd(cm_of(high));
        end
        exp_timeout = exp_to;
        total = exp_at + 8;
        p_cnt = 0;
        p_at  = -1;
        for (int i = 0; i < total; i++) begin
            @(negedge clock);
            if (obs_pronto) begin
                p_cnt++;
                p_at = i;
            end
            echo = (high > 0) && (i >= gap) && (i < gap + high);
            if (busy) medir = (i == gap + high / 2);
        end
        echo  = 1'b0;
        medir = 1'b0;
        ntests += 6;
        if (p_cnt !== 1) begin nfail++; $display("FAIL pronto_count(h=%0d): got %0d required 1", high, p_cnt); end
        if (p_at !== exp_at) begin nfail++; $display("FAIL pronto_time(h=%0d): got %0d required %0d", high, p_at, exp_at); end
        if (obs_medida !== exp_medida) begin nfail++; $display("FAIL medida(h=%0d): got %h required %h", high, obs_medida, exp_medida); end
        if (obs_timeout !== exp_timeout) begin nfail++; $display("FAIL timeout(h=%0d): got %b required %b", high, obs_timeout, exp_timeout); end
        if (obs_estado !== 4'd6) begin nfail++; $display("FAIL final_state(h=%0d): got %0d required 6", high, obs_estado); end
        if (obs_trigger !== 1'b0) begin nfail++; $display("FAIL trigger_idle(h=%0d): got %b required 0", high, obs_trigger); end
    endtask

    task automatic pulse_reset();
        @(negedge clock); reset = 1'b0;
        @(negedge clock); reset = 1'b1;
        exp_medida  = 12'h000;
        exp_timeout = 1'b0;
    endtask

    task automatic test_reset();
        int tcount, first, bad;
        logic [3:0] st_after;
        reset = 1'b0; medir = 1'b0; echo = 1'b0;
        repeat (3) @(negedge clock);
        ntests += 5;
        if (estado_d !== 4'd0) begin nfail++; $display("FAIL reset_state: got %0d required 0", estado_d); end
        if (trigger_d !== 1'b0) begin nfail++; $display("FAIL reset_trigger: got %b required 0", trigger_d); end
        if (medida_d !== 12'h000) begin nfail++; $display("FAIL reset_medida: got %h required 000", medida_d); end
        if (pronto_d !== 1'b0) begin nfail++; $display("FAIL reset_pronto: got %b required 0", pronto_d); end
        if (timeout_d !== 1'b0) begin nfail++; $display("FAIL reset_timeout: got %b required 0", timeout_d); end
        reset = 1'b1; medir = 1'b1;
        @(negedge clock); medir = 1'b0;
        ntests += 2;
        if (estado_d !== 4'd1) begin nfail++; $display("FAIL prepara_state: got %0d required 1", estado_d); end
        if (trigger_d !== 1'b0) begin nfail++; $display("FAIL prepara_trigger: got %b required 0", trigger_d); end
        tcount = 0; first = -1; bad = 0; st_after = 4'd0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (trigger_d) begin
                tcount++;
                if (first < 0) first = i;
                if (estado_d !== 4'd2) bad++;
            end
            if (i == TRIG) st_after = estado_d;
        end
        ntests += 4;
        if (tcount !== TRIG) begin nfail++; $display("FAIL trigger_width: got %0d required %0d", tcount, TRIG); end
        if (first !== 0) begin nfail++; $display("FAIL trigger_start: got %0d required 0", first); end
        if (bad !== 0) begin nfail++; $display("FAIL trigger_state: got %0d cycles outside state 2, required 0", bad); end
        if (st_after !== 4'd3) begin nfail++; $display("FAIL after_trigger_state: got %0d required 3", st_after); end
        pulse_reset();
    endtask

    task automatic test_rounding();
        int lens[5] = '{124, 9, 4, 1999, 125};
        foreach (lens[k]) run_meas(1'b1, $urandom_range(1, 20), lens[k], 1'b0);
        ntests++;
        if (medida_d !== 12'h013) begin nfail++; $display("FAIL medida_125: got %h required 013", medida_d); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) run_meas(1'b1, $urandom_range(1, 20), $urandom_range(1, 400), 1'b0);
        run_meas(1'b1, 2, 125, 1'b0);
    endtask

    task automatic test_missing_echo();
        run_meas(1'b1, 0, 0, 1'b0);
        @(negedge clock); medir = 1'b1;
        @(negedge clock); medir = 1'b0;
        ntests += 2;
        if (estado_d !== 4'd1) begin nfail++; $display("FAIL rearm_state: got %0d required 1", estado_d); end
        if (timeout_d !== 1'b0) begin nfail++; $display("FAIL rearm_timeout: got %b required 0", timeout_d); end
        run_meas(1'b0, $urandom_range(1, 20), $urandom_range(30, 300), 1'b0);
    endtask

    task automatic test_busy();
        run_meas(1'b1, $urandom_range(1, 20), $urandom_range(60, 300), 1'b1);
    endtask

    task automatic test_saturation();
        pulse_reset();
        sel_s = 1'b1;
        run_meas(1'b1, 3, 9996, 1'b0);
        run_meas(1'b1, 5, 20050, 1'b0);
        sel_s = 1'b0;
    endtask

    task automatic test_reset_abort();
        int pcnt, sbad;
        @(negedge clock); medir = 1'b1;
        @(negedge clock); medir = 1'b0;
        @(negedge clock);
        ntests++;
        if (estado_d !== 4'd2 || trigger_d !== 1'b1) begin
            nfail++; $display("FAIL abort_setup: state %0d trigger %b, required 2 and 1", estado_d, trigger_d);
        end
        reset = 1'b0;
        @(negedge clock);
        ntests += 5;
        if (trigger_d !== 1'b0) begin nfail++; $display("FAIL abort_trigger: got %b required 0", trigger_d); end
        if (medida_d !== 12'h000) begin nfail++; $display("FAIL abort_medida: got %h required 000", medida_d); end
        if (pronto_d !== 1'b0) begin nfail++; $display("FAIL abort_pronto: got %b required 0", pronto_d); end
        if (estado_d !== 4'd0) begin nfail++; $display("FAIL abort_state: got %0d required 0", estado_d); end
        if (timeout_d !== 1'b0) begin nfail++; $display("FAIL abort_timeout: got %b required 0", timeout_d); end
        @(negedge clock); reset = 1'b1;
        pcnt = 0; sbad = 0;
        repeat (10) begin
            @(negedge clock);
            if (pronto_d) pcnt++;
            if (estado_d !== 4'd0) sbad++;
        end
        ntests += 2;
        if (pcnt !== 0) begin nfail++; $display("FAIL abort_no_pronto: got %0d pulses required 0", pcnt); end
        if (sbad !== 0) begin nfail++; $display("FAIL abort_idle: got %0d non-idle cycles required 0", sbad); end
    endtask

    initial begin
        reset = 1'b0; medir = 1'b0; echo = 1'b0;
        exp_medida = 12'h000; exp_timeout = 1'b0;
        test_reset();
        test_rounding();
        test_random();
        test_missing_echo();
        test_busy();
        test_saturation();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/exp4_hcsr04_interface.md
Name: exp4_hcsr04_interface

Overview:
- Upstream measurement stage of the ultrasonic tape-measure datapath.
- On a `medir` request it drives the HC-SR04 trigger pulse and times the echo pulse.
- It converts the echo width to rounded centimetres as 3-digit BCD and presents `medida` plus a one-cycle `pronto` to the trena datapath, which serialises and displays the value.
- It also detects a missing or over-long echo and flags it as a timeout.

Parameters:
- TRIGGER_CYCLES, 500: trigger high time in clocks (10 us at 50 MHz).
- CYCLES_PER_CM, 2941: clocks of echo per centimetre (58.82 us at 50 MHz).
- TIMEOUT_CYCLES, 1500000: limit for both the wait-for-echo phase and the echo-high phase (30 ms).

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- medir  in  1  measurement request; level sampled in INICIAL/FINAL.
- echo  in  1  asynchronous sensor echo.
- trigger  out  1  sensor trigger, registered.
- medida  out  12  BCD result {hundreds, tens, units}.
- pronto  out  1  one-cycle pulse when a measurement or timeout completes.
- timeout  out  1  high if the last measurement timed out.
- db_estado  out  4  current state code.

Behaviour:
- Reset (reset=0 at a clock edge):
  - State goes to INICIAL.
  - trigger=0, medida=12'h000, pronto=0, timeout=0.
  - All counters and synchroniser flops are cleared.
  - Reset mid-measurement aborts immediately, with no pronto.
- Echo input:
  - Passes through a 2-flop synchroniser; `echo_s` is the second flop. Only `echo_s` is used.
  - Rise/fall are detected against a registered copy of `echo_s`.
- States and codes:
  - INICIAL=0: idle. If medir=1, go to PREPARA next cycle.
  - PREPARA=1: clear tick, cm and timeout counters, clear timeout flag; go to ENVIA_TRIGGER.
  - ENVIA_TRIGGER=2: trigger=1 for exactly TRIGGER_CYCLES consecutive cycles, then go to ESPERA_ECHO with trigger=0.
  - ESPERA_ECHO=3: wait for `echo_s` rise, which moves to MEDE. If TIMEOUT_CYCLES cycles pass with no rise, go to TIMEOUT.
  - MEDE=4: count cycles while `echo_s`=1. `echo_s` fall moves to ARMAZENA. If the high time reaches TIMEOUT_CYCLES, go to TIMEOUT.
  - ARMAZENA=5: load `medida` from the rounded BCD count; pronto=1 this cycle; go to FINAL.
  - TIMEOUT=15: timeout=1, `medida` unchanged, pronto=1 this cycle; go to FINAL.
  - FINAL=6: idle holding results. If medir=1, go to PREPARA.
- medir is ignored in states 1–5. A medir held high re-triggers back-to-back measurements.
- Arithmetic:
  - N = number of cycles in MEDE with `echo_s`=1.
  - The tick counter wraps at CYCLES_PER_CM-1. Each wrap increments a 3-digit BCD counter with decimal carry.
  - At the fall: cm = floor(N/CYCLES_PER_CM) + (N mod CYCLES_PER_CM >= CYCLES_PER_CM/2), using integer division for CYCLES_PER_CM/2.
  - The result saturates at 999 (12'h999) and never wraps to 000.
- Latency from echo pin fall to pronto is 3 cycles (2 synchroniser cycles plus ARMAZENA).
- `medida` and `timeout` are stable from pronto until the next PREPARA. `medida` keeps its last valid value across a timeout.

Test Plan:
- Bench overrides: TRIGGER_CYCLES=5, CYCLES_PER_CM=10, TIMEOUT_CYCLES=2000.
- Reset check: reset low 3 cycles, then medir=1 for 1 cycle -> trigger high exactly 5 cycles starting 2 cycles after medir is sampled; db_estado sequence 0,1,2,3.
- Normal measurement: echo high 125 cycles -> medida=12'h013, one pronto pulse 3 cycles after echo fall, timeout=0, db_estado=6.
- Rounding boundaries: echo 124 cycles -> 12'h012; 125 cycles -> 12'h013; 9 cycles -> 12'h001; 4 cycles -> 12'h000.
- Missing echo: no echo rise for 2000 cycles after trigger -> pronto pulse, timeout=1, medida still 12'h013, state 6 then 15-free idle. A new medir clears timeout in PREPARA.
- Saturation and over-long echo: (TIMEOUT_CYCLES=20000) echo 9996 cycles -> 12'h999. Echo held high 20000+ cycles -> TIMEOUT, timeout=1.
- Busy and reset abort: medir pulses during MEDE are ignored (single pronto). reset=0 during ENVIA_TRIGGER -> trigger=0 next edge, medida=000, no pronto, state 0.
